// File: rtl/uart_tx.sv
// uart_tx: 16x-oversampled UART transmitter, 1 start / DATA_BITS LSB-first / 1 stop, no parity.
// Define UART_TX_HOLD_BUF_EN for a one-word holding register giving back-to-back frames.
module uart_tx #(
  parameter int DATA_BITS  = 16,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_TICKS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 tx_tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx
);
  localparam int TMAX = OVERSAMPLE > STOP_TICKS ? OVERSAMPLE : STOP_TICKS;
  localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
  localparam int BW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] OS_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic                 accept, stop_end;

`ifdef UART_TX_HOLD_BUF_EN
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_valid_q, hold_valid_d;
  assign tx_ready = enable && !hold_valid_q;
`else
  assign tx_ready = enable && state_q == IDLE;
`endif

  assign accept   = tx_start && tx_ready;
  assign stop_end = state_q == STOP && tx_tick && tick_q == STOP_LAST;
  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

  // tx_d always reflects the output of the state being entered, so tx is a clean flop output
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
`endif
    if (enable) begin
      case (state_q)
        IDLE: begin
          tx_d = 1'b1;
          if (accept) begin
            shift_d = tx_data;
            tick_d  = '0;
            state_d = START;
            tx_d    = 1'b0;
          end
        end
        START: begin
          tx_d = 1'b0;
          if (tx_tick && tick_q == OS_LAST) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = DATA;
            tx_d    = shift_q[0];
          end else if (tx_tick) tick_d = tick_q + 1'b1;
        end
        DATA: begin
          tx_d = shift_q[0];
          if (tx_tick && tick_q == OS_LAST) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            state_d = bit_q == BIT_LAST ? STOP : DATA;
            bit_d   = bit_q == BIT_LAST ? bit_q : bit_q + 1'b1;
            tx_d    = bit_q == BIT_LAST ? 1'b1 : shift_q[1];
          end else if (tx_tick) tick_d = tick_q + 1'b1;
        end
        STOP: begin
          tx_d = 1'b1;
          if (stop_end) begin
            tick_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
`ifdef UART_TX_HOLD_BUF_EN
            if (hold_valid_q || accept) begin
              shift_d      = hold_valid_q ? hold_q : tx_data;
              hold_valid_d = 1'b0;
              state_d      = START;
              tx_d         = 1'b0;
            end
`endif
          end else if (tx_tick) tick_d = tick_q + 1'b1;
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
`ifdef UART_TX_HOLD_BUF_EN
      if (accept && state_q != IDLE && !stop_end) begin
        hold_d       = tx_data;
        hold_valid_d = 1'b1;
      end
`endif
    end
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_HOLD_BUF_EN
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: bench for uart_tx; a line decoder pops expected words pushed at acceptance.
module tb_uart_tx;
  logic        clk = 1'b0, reset_n = 1'b0, enable = 1'b0, tx_tick = 1'b0, tx_start = 1'b0;
  logic [15:0] tx_data = '0;
  logic        tx_ready, tx_busy, tx_done, tx;
  int          n_cmp = 0, n_err = 0, n_done = 0;
  logic [15:0] exp_q[$];

  uart_tx dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .tx_tick(tx_tick), .tx_start(tx_start),
    .tx_data(tx_data), .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx(tx)
  );

  always #5 clk = ~clk;

  initial forever begin
    repeat (3) @(negedge clk);
    tx_tick = 1'b1;
    @(negedge clk);
    tx_tick = 1'b0;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (tx_done === 1'b1) n_done++;
  end

  // Decodes one frame by counting consumed ticks and sampling mid-bit; abandons it on reset
  task automatic mon_frame();
    int ticks = 0, cyc = 0, k;
    logic [15:0] w = '0;
    logic tk, e;
    while (ticks < 288) begin
      @(posedge clk);
      tk = tx_tick && enable;
      #1;
      cyc++;
      if (!reset_n) return;
      if (cyc > 5000) begin
        n_cmp++; n_err++;
        $display("FAIL mon_timeout: got %0d ticks want 288", ticks);
        return;
      end
      if (tk) begin
        ticks++;
        if (ticks % 16 == 8) begin
          k = ticks / 16;
          if (k == 0) begin
            n_cmp++;
            if (tx !== 1'b0) begin n_err++; $display("FAIL start_bit: got %b want 0", tx); end
          end else if (k == 17) begin
            n_cmp++;
            if (tx !== 1'b1) begin n_err++; $display("FAIL stop_bit: got %b want 1", tx); end
          end else w[k-1] = tx;
        end
      end
    end
    n_cmp++;
    if (tx_done !== 1'b1) begin n_err++; $display("FAIL frame_end_done: got %b want 1 at tick 288", tx_done); end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++; $display("FAIL unexpected_frame: got %h want none", w);
    end else begin
      e = 1'b0;
      if (w !== exp_q[0]) begin e = 1'b1; n_err++; $display("FAIL frame_data: got %h want %h", w, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    logic prev;
    prev = 1'b1;
    @(posedge clk);
    #1;
    forever begin
      if (reset_n && prev && tx === 1'b0) begin
        mon_frame();
        prev = 1'b1;
      end else begin
        prev = tx;
        @(posedge clk);
        #1;
      end
    end
  end

  task automatic send(input logic [15:0] w, input bit push);
    int n = 0;
    logic was_idle;
    @(negedge clk);
    while (!tx_ready && n < 3000) begin @(negedge clk); n++; end
    if (!tx_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_ready: got %b want 1", tx_ready);
      return;
    end
    was_idle = !tx_busy;
    tx_data  = w;
    tx_start = 1'b1;
    if (push) exp_q.push_back(w);
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    if (was_idle) begin
      n_cmp++;
      if (tx !== 1'b0 || tx_busy !== 1'b1) begin
        n_err++; $display("FAIL accept_latency: got tx=%b busy=%b want tx=0 busy=1", tx, tx_busy);
      end
    end
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (n_done < target && n < 4000) begin @(posedge clk); #2; n++; end
    repeat (5) @(posedge clk);
    #2;
    n_cmp++;
    if (n_done != target) begin n_err++; $display("FAIL %s: got %0d done pulses want %0d", name, n_done, target); end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_cmp++;
    if (tx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    n_cmp++;
    if (tx_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", tx_done); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (tx_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
    enable = 1'b0;
    #1;
    n_cmp++;
    if (tx_ready !== 1'b0) begin n_err++; $display("FAIL disabled_ready: got %b want 0", tx_ready); end
    enable = 1'b1;
  endtask

  task automatic test_single();
    int base = n_done;
    send(16'hA5C3, 1'b1);
    wait_done(base + 1, "single_done");
    @(negedge clk);
    n_cmp++;
    if (tx_ready !== 1'b1 || tx !== 1'b1 || tx_busy !== 1'b0) begin
      n_err++; $display("FAIL single_idle: got ready=%b tx=%b busy=%b want 1 1 0", tx_ready, tx, tx_busy);
    end
  endtask

  task automatic test_loopback();
    logic [15:0] words[4] = '{16'h0001, 16'h8000, 16'hFFFF, 16'h0000};
    foreach (words[i]) begin
      int base = n_done;
      send(words[i], 1'b1);
      wait_done(base + 1, "loop_done");
    end
  endtask

  task automatic test_busy();
    int base = n_done;
    send(16'hA5C3, 1'b1);
    repeat (100) @(negedge clk);
    tx_data  = 16'h1234;
    tx_start = 1'b1;
    n_cmp++;
    if (tx_ready !== 1'b0) begin n_err++; $display("FAIL busy_ready: got %b want 0", tx_ready); end
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    wait_done(base + 1, "busy_done");
    repeat (300) @(negedge clk);
    n_cmp++;
    if (n_done != base + 1 || tx_busy !== 1'b0) begin
      n_err++; $display("FAIL busy_dropped: got done=%0d busy=%b want %0d 0", n_done - base, tx_busy, 1);
    end
  endtask

  task automatic test_enable();
    int base = n_done, bad = 0;
    logic lvl, bsy;
    send(16'h5A5A, 1'b1);
    repeat (420) @(negedge clk);
    enable   = 1'b0;
    tx_start = 1'b1;
    tx_data  = 16'hFFFF;
    #1;
    lvl = tx;
    bsy = tx_busy;
    n_cmp++;
    if (tx_ready !== 1'b0) begin n_err++; $display("FAIL freeze_ready: got %b want 0", tx_ready); end
    repeat (100) begin
      @(negedge clk);
      if (tx !== lvl || tx_busy !== bsy || n_done != base) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL freeze_hold: got %0d changed cycles want 0", bad); end
    tx_start = 1'b0;
    enable   = 1'b1;
    wait_done(base + 1, "freeze_done");
  endtask

  task automatic test_abort();
    int base = n_done;
    send(16'h3C3C, 1'b0);
    repeat (672) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      n_err++; $display("FAIL abort_now: got tx=%b busy=%b want 1 0", tx, tx_busy);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (1200) @(negedge clk);
    n_cmp++;
    if (n_done != base || tx !== 1'b1 || tx_ready !== 1'b1) begin
      n_err++; $display("FAIL abort_idle: got done=%0d tx=%b ready=%b want 0 1 1", n_done - base, tx, tx_ready);
    end
  endtask

`ifdef UART_TX_HOLD_BUF_EN
  task automatic test_hold();
    int base = n_done, n = 0;
    send(16'hBEEF, 1'b1);
    repeat (40) @(negedge clk);
    send(16'hCAFE, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (tx_ready !== 1'b0) begin n_err++; $display("FAIL hold_full_ready: got %b want 0", tx_ready); end
    tx_data  = 16'h1111;
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    do begin @(posedge clk); #1; n++; end while (tx_done !== 1'b1 && n < 3000);
    n_cmp++;
    if (tx_done !== 1'b1 || tx !== 1'b0) begin
      n_err++; $display("FAIL b2b_start: got done=%b tx=%b want 1 0", tx_done, tx);
    end
    wait_done(base + 2, "hold_done");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_loopback();
`ifdef UART_TX_HOLD_BUF_EN
    test_hold();
`else
    test_busy();
`endif
    test_enable();
    test_abort();
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
